xgriscv_lsu: RTL and testbench
==============================

# xgriscv_lsu

Load/store unit between the execute stage and `dmem`. It accepts one memory request at a time over a valid/ready handshake. It drives the `dmem` port with only the byte-enable patterns `dmem` supports, and splits every misaligned access into a sequence of single-byte beats. It returns aligned, sign- or zero-extended load data with a one-cycle response pulse.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `DM_AW`, 9: `dmem` byte-address width (512 bytes).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: `00` byte, `01` half, `10` word; `11` is treated as word.
- `req_unsigned` in 1: zero-extend the load (lbu/lhu).
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out XLEN: load result; 0 for stores and errors.
- `rsp_err` out 1: out-of-range access; valid with `rsp_valid`.
- `dm_we` out 1: `dmem` write enable.
- `dm_amp` out 4: `dmem` byte mask.
- `dm_a` out DM_AW: `dmem` byte address.
- `dm_wd` out XLEN: `dmem` write data, right-justified.
- `dm_rd` in XLEN: `dmem` combinational read word.

## Operation
States: IDLE, ACC, BYTE, RESP.
- IDLE:
  - `req_ready`=1; on handshake the request is registered as addr, size, we, unsigned, wdata.
  - Out of range (addr+bytes-1 > 2^DM_AW-1, or any addr bit ≥ DM_AW set) → RESP with err=1.
  - Aligned (byte; half with addr[0]=0; word with addr[1:0]=0) → ACC.
  - Otherwise → BYTE with beat counter k=0 and N = 2 (half) or 4 (word).
- ACC, one cycle:
  - `dm_a` = addr.
  - `dm_amp`: 1111 for a word; 0011 or 1100 for a half, by addr[1]; one-hot `1<<addr[1:0]` for a byte.
  - `dm_wd` = wdata; `dm_we` = we.
  - A load captures the lane from `dm_rd` at the edge.
  - Next state is RESP.
- BYTE, one beat per cycle:
  - `dm_a` = addr+k; `dm_amp` = `1<<(addr+k)[1:0]`; `dm_wd[7:0]` = wdata[8k+7:8k], upper bits 0; `dm_we` = we.
  - A load writes lane byte `(addr+k)[1:0]` of `dm_rd` into result byte k.
  - After beat k = N-1 → RESP.
- RESP, one cycle: `rsp_valid`=1, then → IDLE.
- Load extension: bit 7 (byte) or bit 15 (half) is replicated unless `req_unsigned`; a word load is passed through.
- Outside ACC/BYTE: `dm_we`=0, `dm_amp`=0000, `dm_a`=0, `dm_wd`=0.
- The `dmem` default case (full-word write for an unsupported mask) is never reachable from this block.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `dm_*` outputs 0.
- Latency from the acceptance edge to `rsp_valid`:
  - aligned: 2 cycles;
  - misaligned half: 3 cycles;
  - misaligned word: 5 cycles;
  - error: 1 cycle.
- `req_ready`=0 outside IDLE, so requests are not pipelined. Sustained aligned throughput is one request per 3 cycles.
- `rsp_rdata` and `rsp_err` are held until the next `rsp_valid`; they are meaningful only while `rsp_valid`=1.
- A store word is visible in `dmem` at the edge ending its ACC/BYTE beat.
- Boundary conditions:
  - Word at 0x1FD–0x1FF → err, no write.
  - Half at 0x1FE → aligned ACC.
  - Half at 0x1FF → err.
- Reset asserted mid-BYTE: the FSM returns to IDLE immediately and no `rsp_valid` is produced. Bytes already written stay in `dmem` (no rollback).

## Structure
- Shared package (`xgriscv_defines`): size encodings `SZ_B`/`SZ_H`/`SZ_W`, `DMEM_BYTES`, and the LSU state encoding.
- Sub-module `xgriscv_lsu_ext`: combinational lane select plus sign/zero extension. It is reused by the writeback mux.
- The main module holds the FSM, beat counter, request registers, result byte register and `dmem` drive.

## Test plan
- Aligned word store/load: `sw` 0xDEADBEEF at 0x10, then `lw` 0x10.
  - Store: `dm_amp`=1111 for one cycle.
  - Load: `rsp_rdata`=0xDEADBEEF two cycles after acceptance, `rsp_err`=0.
- Byte lanes: `sb` 0x80 at 0x0D.
  - `dm_amp`=0010, `dm_wd`=0x80.
  - `lb` 0x0D returns 0xFFFFFF80; `lbu` 0x0D returns 0x00000080.
- Misaligned word: `sw` 0x44332211 at 0x05.
  - Four beats, amps 0010, 0100, 1000, 0001; `dm_a` 5, 6, 7, 8.
  - `rsp_valid` 5 cycles after acceptance.
  - `lw` 0x05 returns 0x44332211.
- Misaligned half: preload word 0x0 = 0x80000000 and word 0x4 = 0x00000001, then `lh` 0x03.
  - Two beats; `rsp_rdata`=0x00000180.
  - `lhu` 0x03 also returns 0x00000180.
- Out of range: `sw` at 0x1FE (word) or 0x200 (byte).
  - `dm_we` never high; `rsp_err`=1 one cycle after acceptance; `rsp_rdata`=0.
- Reset during beat 2 of the 0x05 word store:
  - Outputs return to reset values asynchronously; no `rsp_valid`.
  - Bytes 0x05–0x06 hold new data, 0x07–0x08 hold old data.
  - The next request is accepted normally.

Source files
------------

// File: rtl/xgriscv_defines.sv
// Shared LSU definitions: access-size encodings, data-memory size and FSM state encoding.
package xgriscv_defines;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int DMEM_BYTES = 512;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Number of bytes touched by an access; 2'b11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/xgriscv_lsu_ext.sv
// Load lane select and sign/zero extension; shared with the writeback mux.
module xgriscv_lsu_ext
  import xgriscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane = word >> {off, 3'b000};
    case (size)
      SZ_B:    data = {{(XLEN-8){lane[7] & ~is_unsigned}}, lane[7:0]};
      SZ_H:    data = {{(XLEN-16){lane[15] & ~is_unsigned}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit: one request at a time, aligned accesses in one dmem cycle,
// misaligned accesses split into single-byte beats.
module xgriscv_lsu
  import xgriscv_defines::*;
#(
  parameter int XLEN  = 32,
  parameter int DM_AW = $clog2(DMEM_BYTES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err,
  output logic             dm_we,
  output logic [3:0]       dm_amp,
  output logic [DM_AW-1:0] dm_a,
  output logic [XLEN-1:0]  dm_wd,
  input  logic [XLEN-1:0]  dm_rd
);

  localparam int AW1 = XLEN + 1;

  logic [1:0]       state_reg;
  logic [DM_AW-1:0] addr_reg;
  logic [1:0]       size_reg;
  logic             we_reg;
  logic             uns_reg;
  logic [XLEN-1:0]  wdata_reg;
  logic [1:0]       k_reg;
  logic [XLEN-1:0]  buf_reg;
  logic [XLEN-1:0]  rdata_reg;
  logic             err_reg;

  logic [1:0]       size_in;
  logic [XLEN:0]    last_byte;
  logic             out_of_range;
  logic             aligned;
  logic             last_beat;
  logic [DM_AW-1:0] beat_a;
  logic [7:0]       rd_lane;
  logic [XLEN-1:0]  merged;
  logic [XLEN-1:0]  ext_word;
  logic [1:0]       ext_off;
  logic [XLEN-1:0]  ext_data;

  // Request decode; the extra top bit of last_byte catches address wrap.
  assign size_in      = (req_size == 2'b11) ? SZ_W : req_size;
  assign last_byte    = {1'b0, req_addr} + AW1'(size_bytes(size_in)) - AW1'(1);
  assign out_of_range = |last_byte[XLEN:DM_AW];

  always_comb begin
    case (size_in)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~req_addr[0];
      default: aligned = (req_addr[1:0] == 2'b00);
    endcase
  end

  assign last_beat = (k_reg == ((size_reg == SZ_H) ? 2'd1 : 2'd3));
  assign beat_a    = addr_reg + DM_AW'(k_reg);
  assign rd_lane   = dm_rd[{beat_a[1:0], 3'b000} +: 8];

  // Result word with the current beat's byte dropped into slot k.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN / 8; gi++) begin : g_merge
      assign merged[8*gi +: 8] = (k_reg == 2'(gi)) ? rd_lane : buf_reg[8*gi +: 8];
    end
  endgenerate

  assign ext_word = (state_reg == ST_ACC) ? dm_rd : merged;
  assign ext_off  = (state_reg == ST_ACC) ? addr_reg[1:0] : 2'b00;

  xgriscv_lsu_ext #(.XLEN(XLEN)) u_ext (
    .word        (ext_word),
    .off         (ext_off),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .data        (ext_data)
  );

  always_comb begin
    dm_we  = 1'b0;
    dm_amp = 4'b0000;
    dm_a   = '0;
    dm_wd  = '0;
    case (state_reg)
      ST_ACC: begin
        dm_we = we_reg;
        dm_a  = addr_reg;
        dm_wd = wdata_reg;
        case (size_reg)
          SZ_B:    dm_amp = 4'b0001 << addr_reg[1:0];
          SZ_H:    dm_amp = addr_reg[1] ? 4'b1100 : 4'b0011;
          default: dm_amp = 4'b1111;
        endcase
      end
      ST_BYTE: begin
        dm_we  = we_reg;
        dm_a   = beat_a;
        dm_amp = 4'b0001 << beat_a[1:0];
        dm_wd  = XLEN'(wdata_reg[{k_reg, 3'b000} +: 8]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      size_reg  <= SZ_B;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      wdata_reg <= '0;
      k_reg     <= 2'd0;
      buf_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr[DM_AW-1:0];
            size_reg  <= size_in;
            we_reg    <= req_we;
            uns_reg   <= req_unsigned;
            wdata_reg <= req_wdata;
            k_reg     <= 2'd0;
            buf_reg   <= '0;
            if (out_of_range) begin
              rdata_reg <= '0;
              err_reg   <= 1'b1;
              state_reg <= ST_RESP;
            end else if (aligned) begin
              state_reg <= ST_ACC;
            end else begin
              state_reg <= ST_BYTE;
            end
          end
        end
        ST_ACC: begin
          rdata_reg <= we_reg ? '0 : ext_data;
          err_reg   <= 1'b0;
          state_reg <= ST_RESP;
        end
        ST_BYTE: begin
          buf_reg <= merged;
          k_reg   <= k_reg + 2'd1;
          if (last_beat) begin
            rdata_reg <= we_reg ? '0 : ext_data;
            err_reg   <= 1'b0;
            state_reg <= ST_RESP;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Self-checking bench: directed cases plus random traffic against a byte-array reference model.
module tb_xgriscv_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dm_we;
  logic [3:0]  dm_amp;
  logic [8:0]  dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:511];
  logic [7:0] ref_mem [0:511];
  logic       fill_en = 1'b0;
  logic [8:0] fill_addr = '0;
  logic [7:0] fill_data = '0;

  logic [3:0]  amp_q [$];
  logic [8:0]  a_q [$];
  logic [31:0] wd_q [$];

  xgriscv_lsu #(.XLEN(32), .DM_AW(9)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm_we(dm_we), .dm_amp(dm_amp), .dm_a(dm_a),
    .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // dmem model: right-justified write data, mask selects byte/half/word.
  assign dm_rd = {mem[{dm_a[8:2], 2'd3}], mem[{dm_a[8:2], 2'd2}],
                  mem[{dm_a[8:2], 2'd1}], mem[{dm_a[8:2], 2'd0}]};

  always @(posedge clk) begin
    if (fill_en) begin
      mem[fill_addr] <= fill_data;
    end else if (dm_we) begin
      case (dm_amp)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: mem[dm_a] <= dm_wd[7:0];
        4'b0011, 4'b1100: begin
          mem[{dm_a[8:1], 1'b0}] <= dm_wd[7:0];
          mem[{dm_a[8:1], 1'b1}] <= dm_wd[15:8];
        end
        default: begin
          mem[{dm_a[8:2], 2'd0}] <= dm_wd[7:0];
          mem[{dm_a[8:2], 2'd1}] <= dm_wd[15:8];
          mem[{dm_a[8:2], 2'd2}] <= dm_wd[23:16];
          mem[{dm_a[8:2], 2'd3}] <= dm_wd[31:24];
        end
      endcase
    end
  end

  function automatic logic amp_ok(input logic [3:0] amp, input logic [1:0] lo);
    case (amp)
      4'b1111, 4'b0011, 4'b0001: return lo == 2'd0;
      4'b1100, 4'b0100:          return lo == 2'd2;
      4'b0010:                   return lo == 2'd1;
      4'b1000:                   return lo == 2'd3;
      default:                   return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (dm_amp != 4'b0000 || dm_we) begin
      check("amp_legal", {31'b0, amp_ok(dm_amp, dm_a[1:0])}, 32'd1);
      amp_q.push_back(dm_amp);
      a_q.push_back(dm_a);
      wd_q.push_back(dm_wd);
    end
  end

  // Reference: whole-access semantics on a byte array.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    int n;
    longint last;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'(addr) + n - 1;
    rd = 32'd0;
    err = (last > 511);
    if (err) begin
      lat = 1;
    end else begin
      lat = (addr % n == 0) ? 2 : ((n == 2) ? 3 : 5);
      for (int i = 0; i < n; i++) begin
        if (we) ref_mem[addr + i] = wd[8*i +: 8];
        else rd = rd | (32'(ref_mem[addr + i]) << (8 * i));
      end
      if (!we && !uns && n == 1 && rd[7]) rd = rd | 32'hFFFFFF00;
      if (!we && !uns && n == 2 && rd[15]) rd = rd | 32'hFFFF0000;
    end
  endtask

  // Starts and ends on a negedge with the DUT idle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err, output int got_lat);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    model(we, sz, uns, addr, wd, e_rd, e_err, e_lat);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 20) begin
      check("ready_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      got_lat++;
    end
    got_rd = rsp_rdata;
    got_err = rsp_err;
    $display("req we=%0d sz=%0d uns=%0d addr=%08h wd=%08h -> rd=%08h err=%0d lat=%0d",
             we, sz, uns, addr, wd, got_rd, got_err, got_lat);
    check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    check("latency", 32'(got_lat), 32'(e_lat));
    check("rdata", got_rd, e_rd);
    check("err", {31'b0, got_err}, {31'b0, e_err});
    @(negedge clk);
    check("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic clear_q();
    amp_q.delete(); a_q.delete(); wd_q.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r;

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      fill_en = 1'b1; fill_addr = 9'(i); fill_data = 8'($urandom);
      ref_mem[i] = fill_data;
    end
    @(negedge clk);
    fill_en = 1'b0;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_dm", {dm_we, dm_amp, dm_a, dm_wd[17:0]}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    clear_q();

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("sw_amp_n", 32'(amp_q.size()), 32'd1);
    if (amp_q.size() == 1) check("sw_amp", {28'b0, amp_q[0]}, 32'hF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_lat", 32'(lat), 32'd2);

    clear_q();
    do_req(1'b1, 2'd0, 1'b0, 32'h0D, 32'h80, rd, er, lat);
    check("sb_amp_n", 32'(amp_q.size()), 32'd1);
    if (amp_q.size() == 1) begin
      check("sb_amp", {28'b0, amp_q[0]}, 32'h2);
      check("sb_wd", wd_q[0], 32'h80);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, rd, er, lat);
    check("lb_data", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, rd, er, lat);
    check("lbu_data", rd, 32'h00000080);

    clear_q();
    do_req(1'b1, 2'd2, 1'b0, 32'h05, 32'h44332211, rd, er, lat);
    check("msw_lat", 32'(lat), 32'd5);
    check("msw_beats", 32'(amp_q.size()), 32'd4);
    if (amp_q.size() == 4) begin
      check("msw_amps", {16'b0, amp_q[0], amp_q[1], amp_q[2], amp_q[3]}, 32'h2481);
      check("msw_addrs", {a_q[0][7:0], a_q[1][7:0], a_q[2][7:0], a_q[3][7:0]}, 32'h05060708);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, rd, er, lat);
    check("mlw_data", rd, 32'h44332211);

    do_req(1'b1, 2'd2, 1'b0, 32'h00, 32'h80000000, rd, er, lat);
    do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'h00000001, rd, er, lat);
    clear_q();
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, rd, er, lat);
    check("mlh_data", rd, 32'h00000180);
    check("mlh_lat", 32'(lat), 32'd3);
    check("mlh_beats", 32'(amp_q.size()), 32'd2);
    do_req(1'b0, 2'd1, 1'b1, 32'h03, 32'h0, rd, er, lat);
    check("mlhu_data", rd, 32'h00000180);

    clear_q();
    do_req(1'b1, 2'd2, 1'b0, 32'h1FE, 32'hCAFEF00D, rd, er, lat);
    check("oor_w_err", {31'b0, er}, 32'd1);
    check("oor_w_lat", 32'(lat), 32'd1);
    do_req(1'b1, 2'd0, 1'b0, 32'h200, 32'h5A, rd, er, lat);
    check("oor_b_err", {31'b0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h1FD, 32'h12345678, rd, er, lat);
    check("oor_no_write", 32'(amp_q.size()), 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h1FE, 32'h0, rd, er, lat);
    check("h1fe_lat", 32'(lat), 32'd2);
    check("h1fe_err", {31'b0, er}, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h1FF, 32'h0, rd, er, lat);
    check("h1ff_err", {31'b0, er}, 32'd1);
    check("h1ff_rdata", rd, 32'd0);

    // Reset in the third beat of a misaligned word store.
    do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'h0, rd, er, lat);
    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h05; req_wdata = 32'h44332211;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rb_beat0", {23'b0, dm_a}, 32'h5);
    @(negedge clk);
    check("rb_beat1", {23'b0, dm_a}, 32'h6);
    @(negedge clk);
    check("rb_beat2", {23'b0, dm_a}, 32'h7);
    rstn = 1'b0;
    #1;
    check("ar_ready", {31'b0, req_ready}, 32'd1);
    check("ar_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("ar_rdata", rsp_rdata, 32'd0);
    check("ar_dm", {dm_we, dm_amp, dm_a, dm_wd[17:0]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rstn = 1'b1;
    check("ar_b5", {24'b0, mem[5]}, 32'h11);
    check("ar_b6", {24'b0, mem[6]}, 32'h22);
    check("ar_b7", {24'b0, mem[7]}, 32'h00);
    check("ar_b8", {24'b0, mem[8]}, 32'h00);
    ref_mem[5] = 8'h11;
    ref_mem[6] = 8'h22;
    @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, er, lat);
    check("ar_after", rd, 32'h00221100);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r == 0) ad = 32'h1F8 + 32'($urandom_range(0, 15));
      else if (r == 1) ad = $urandom;
      else ad = 32'($urandom_range(0, 511));
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, rd, er, lat);
    end

    for (int i = 0; i < 512; i++) check("mem_final", {24'b0, mem[i]}, {24'b0, ref_mem[i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
